// File: rtl/bit_serializer_if.sv
// ---------------------------------------------------------------------------
// bit_serializer_if
//   Handshake and serial-output bundle for bit_serializer.
//
//   Signals:
//     din        parallel word to serialize (WIDTH bits)
//     din_valid  din holds a word to transfer
//     din_ready  serializer can accept a word this cycle
//     x_out      serial bit stream
//     bit_valid  x_out carries a frame bit this cycle
//     last_bit   x_out is the final bit of the frame
//     busy       serializer is not idle
//
//   Modports:
//     slave   - the serializer (consumes din, produces the serial stream)
//     master  - the word source / stream observer
// ---------------------------------------------------------------------------
interface bit_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             x_out;
  logic             bit_valid;
  logic             last_bit;
  logic             busy;

  modport slave (
    input  din,
    input  din_valid,
    output din_ready,
    output x_out,
    output bit_valid,
    output last_bit,
    output busy
  );

  modport master (
    output din,
    output din_valid,
    input  din_ready,
    input  x_out,
    input  bit_valid,
    input  last_bit,
    input  busy
  );
endinterface

// File: rtl/bit_serializer.sv
// ---------------------------------------------------------------------------
// bit_serializer
//   Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out
//   one bit per cycle on x_out, optionally followed by an even-parity bit,
//   then idles for GAP cycles before accepting the next word.
//
//   Parameters:
//     WIDTH      data bits per word (2..32)
//     GAP        forced idle cycles after each frame (0..15)
//     MSB_FIRST  1: din[WIDTH-1] first, 0: din[0] first
//
//   Ports:
//     clk        rising-edge clock
//     rst        synchronous, active-high reset
//     bus        bit_serializer_if.slave (din/din_valid in; din_ready,
//                x_out, bit_valid, last_bit, busy out)
//
//   Optional feature:
//     Define BIT_SERIALIZER_PARITY_EN to append one even-parity bit
//     (XOR of the captured word) as the final frame bit.
//
//   Timing: a word transferred in cycle 0 shows its first bit in cycle 1;
//   the word-to-word period is 1 + WIDTH + P + GAP cycles (P = parity bit).
// ---------------------------------------------------------------------------
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter int GAP       = 1,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  bit_serializer_if.slave   bus
);

  localparam int                CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [3:0]        GAP_LAST = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

`ifdef BIT_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_GAP    = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd3
  } state_e;
`endif

  // Where the FSM goes once the frame's last bit has been shown.
  localparam state_e AFTER_FRAME = (GAP > 0) ? ST_GAP : ST_IDLE;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [3:0]       gap_q,   gap_d;
  logic             x_out_q, x_out_d;
  logic             bit_valid_q, bit_valid_d;
  logic             last_bit_q,  last_bit_d;
`ifdef BIT_SERIALIZER_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic transfer;

  // The bit currently at the output end of the shift register.
  function automatic logic head_bit(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  // Drop the head bit and bring the next one into position.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
  endfunction

  assign bus.din_ready = (state_q == ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign transfer      = bus.din_valid && (state_q == ST_IDLE);

  // Next-state and registered-output computation.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
`ifdef BIT_SERIALIZER_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (transfer) begin
          shreg_d  = bus.din;
          cnt_d    = '0;
          state_d  = ST_SHIFT;
`ifdef BIT_SERIALIZER_PARITY_EN
          parity_d = ^bus.din;
`endif
        end
      end

      // shreg_q's head bit is the one on x_out this cycle; cnt_q is its index.
      ST_SHIFT: begin
        if (cnt_q == CNT_LAST) begin
`ifdef BIT_SERIALIZER_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = AFTER_FRAME;
`endif
          gap_d   = '0;
        end else begin
          shreg_d = advance(shreg_q);
          cnt_d   = cnt_q + 1'b1;
        end
      end

`ifdef BIT_SERIALIZER_PARITY_EN
      ST_PARITY: begin
        state_d = AFTER_FRAME;
        gap_d   = '0;
      end
`endif

      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered, so they are derived from the state being
    // entered: this gives the first bit one cycle after the transfer.
    x_out_d     = 1'b0;
    bit_valid_d = 1'b0;
    last_bit_d  = 1'b0;
    if (state_d == ST_SHIFT) begin
      x_out_d     = head_bit(shreg_d);
      bit_valid_d = 1'b1;
`ifndef BIT_SERIALIZER_PARITY_EN
      last_bit_d  = (cnt_d == CNT_LAST);
`endif
    end
`ifdef BIT_SERIALIZER_PARITY_EN
    else if (state_d == ST_PARITY) begin
      x_out_d     = parity_d;
      bit_valid_d = 1'b1;
      last_bit_d  = 1'b1;
    end
`endif
  end

  // Reset wins over everything, including a transfer on the same edge.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      gap_q       <= '0;
      x_out_q     <= 1'b0;
      bit_valid_q <= 1'b0;
      last_bit_q  <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      x_out_q     <= x_out_d;
      bit_valid_q <= bit_valid_d;
      last_bit_q  <= last_bit_d;
`ifdef BIT_SERIALIZER_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  assign bus.x_out     = x_out_q;
  assign bus.bit_valid = bit_valid_q;
  assign bus.last_bit  = last_bit_q;

endmodule
